irq_aggregator: RTL and testbench

- Avalon-MM slave that collects the Nios II system's peripheral interrupt lines into one CPU interrupt. Sources include the interval timer irq, the SD controller and UART.
- Sits directly downstream of the interval timer and consumes its level irq.
- Per-source masking, level or rising-edge capture, write-1-to-clear pending bits, software-set bits, and a priority vector register so the ISR finds the highest-priority source in one read.

---
 rtl/irq_aggregator_pkg.sv | 33 +++
 rtl/irq_aggregator_capture_bit.sv | 69 ++++++
 rtl/irq_aggregator.sv | 134 +++++++++++++
 tb/tb_irq_aggregator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_aggregator_pkg.sv
// Shared constants and helpers for the interrupt aggregator register block.
// Register word offsets, vector layout and the lowest-index priority search.
package irq_aggregator_pkg;

  localparam int MAX_IRQ          = 16;
  localparam int VECTOR_VALID_BIT = 15;

  localparam logic [2:0] ADDR_RAW      = 3'd0;
  localparam logic [2:0] ADDR_PENDING  = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_SWSET    = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } vec_t;

  // Scans high to low so the lowest set index is the last one written.
  function automatic vec_t lowest_set(input logic [MAX_IRQ-1:0] v);
    vec_t r;
    r = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_aggregator_capture_bit.sv
// irq_capture_bit: sampling (optionally IRQ_SYNC_EN two-flop sync), edge detect
// and pending state for a single interrupt source.
module irq_capture_bit
  import irq_aggregator_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic mode_chg_i,
  input  logic sw_set_i,
  input  logic clr_i,
  output logic raw_o,
  output logic pending_o
);

  logic s_q;
  logic s_dly_q;
  logic edge_pend_q;
  logic edge_pend_d;
  logic rise;

`ifdef IRQ_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      meta_q <= irq_i;
      s_q    <= meta_q;
    end
  end
`else
  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_q <= 1'b0;
    else          s_q <= irq_i;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_dly_q <= 1'b0;
    else          s_dly_q <= s_q;
  end

  assign rise = s_q & ~s_dly_q;

  // A mode change wins over everything; within edge mode a set beats a clear.
  always_comb begin
    edge_pend_d = edge_pend_q;
    if (mode_chg_i) begin
      edge_pend_d = 1'b0;
    end else if (edge_mode_i) begin
      if (rise || sw_set_i) edge_pend_d = 1'b1;
      else if (clr_i)       edge_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_pend_q <= 1'b0;
    else          edge_pend_q <= edge_pend_d;
  end

  assign raw_o     = s_q;
  assign pending_o = edge_mode_i ? edge_pend_q : s_q;

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source mask, level/edge capture, W1C
// pending, software set and a priority vector. Optional macro: IRQ_SYNC_EN.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  logic               wr_en;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_esel;
  logic               wr_swset;
  logic [NUM_IRQ-1:0] wdata;
  logic               unused_wdata;

  logic [NUM_IRQ-1:0] mask_q,  mask_d;
  logic [NUM_IRQ-1:0] esel_q,  esel_d;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] raw;
  logic [NUM_IRQ-1:0] pending;

  logic [MAX_IRQ-1:0] raw_ext;
  logic [MAX_IRQ-1:0] pend_ext;
  logic [MAX_IRQ-1:0] mask_ext;
  logic [MAX_IRQ-1:0] esel_ext;
  logic [15:0]        vector_word;
  vec_t               vec;

  logic [15:0]        readdata_q, readdata_d;
  logic               irq_out_q,  irq_out_d;

  assign wr_en    = chipselect && !write_n;
  assign wr_pend  = wr_en && (address == ADDR_PENDING);
  assign wr_mask  = wr_en && (address == ADDR_MASK);
  assign wr_esel  = wr_en && (address == ADDR_EDGE_SEL);
  assign wr_swset = wr_en && (address == ADDR_SWSET);

  // Bits at or above NUM_IRQ are dropped here and never stored.
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata;

  assign mode_chg = wr_esel ? (wdata ^ esel_q) : '0;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_bit
    irq_capture_bit u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .irq_i       (irq_in[g]),
      .edge_mode_i (esel_q[g]),
      .mode_chg_i  (mode_chg[g]),
      .sw_set_i    (wr_swset & wdata[g]),
      .clr_i       (wr_pend & wdata[g]),
      .raw_o       (raw[g]),
      .pending_o   (pending[g])
    );
  end

  always_comb begin
    mask_d = mask_q;
    esel_d = esel_q;
    if (wr_mask) mask_d = wdata;
    if (wr_esel) esel_d = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      esel_q <= '0;
    end else begin
      mask_q <= mask_d;
      esel_q <= esel_d;
    end
  end

  // Zero-extend to the full register width so unused bits read back 0.
  always_comb begin
    raw_ext  = '0;
    pend_ext = '0;
    mask_ext = '0;
    esel_ext = '0;
    raw_ext[NUM_IRQ-1:0]  = raw;
    pend_ext[NUM_IRQ-1:0] = pending;
    mask_ext[NUM_IRQ-1:0] = mask_q;
    esel_ext[NUM_IRQ-1:0] = esel_q;
  end

  assign vec = lowest_set(pend_ext & mask_ext);

  always_comb begin
    vector_word                   = '0;
    vector_word[VECTOR_VALID_BIT] = vec.valid;
    vector_word[3:0]              = vec.idx;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_RAW:      readdata_d = raw_ext;
      ADDR_PENDING:  readdata_d = pend_ext;
      ADDR_MASK:     readdata_d = mask_ext;
      ADDR_EDGE_SEL: readdata_d = esel_ext;
      ADDR_VECTOR:   readdata_d = vector_word;
      default:       readdata_d = '0;
    endcase
  end

  assign irq_out_d = |(pending & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Scoreboard bench for irq_aggregator: a cycle model predicts readdata/irq_out,
// a negedge monitor compares. Honours IRQ_SYNC_EN when defined.
module tb_irq_aggregator;
  import irq_aggregator_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [N-1:0]  irq_in = '0;
  logic [15:0]   readdata;
  logic          irq_out;

  always #5 clk = ~clk;

  irq_aggregator #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq_out    (irq_out)
  );

  typedef struct {
    logic [15:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: sampled levels, delayed levels, edge latches, registers.
  logic [N-1:0] m_sync, m_s, m_sd, m_pe, m_mask, m_esel;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_pending();
    return (m_esel & m_pe) | (~m_esel & m_s);
  endfunction

  function automatic logic [15:0] m_vector();
    logic [N-1:0] act;
    act = m_pending() & m_mask;
    for (int i = 0; i < N; i++)
      if (act[i]) return 16'h8000 | 16'(i);
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_sync = '0; m_s = '0; m_sd = '0; m_pe = '0; m_mask = '0; m_esel = '0;
  endtask

  // Called at each rising edge: predicts the registered outputs, then advances.
  task automatic model_step();
    exp_t         e;
    logic [N-1:0] pend, nxt_pe;
    logic         wr;
    if (!reset_n) begin
      model_reset();
      e.rd = '0; e.irq = 1'b0;
      exp_q.push_back(e);
      return;
    end
    pend = m_pending();
    case (address)
      3'd0:    e.rd = 16'(m_s);
      3'd1:    e.rd = 16'(pend);
      3'd2:    e.rd = 16'(m_mask);
      3'd3:    e.rd = 16'(m_esel);
      3'd4:    e.rd = m_vector();
      default: e.rd = 16'h0000;
    endcase
    e.irq = |(pend & m_mask);
    wr = chipselect && !write_n;
    for (int i = 0; i < N; i++) begin
      if (wr && address == 3'd3 && writedata[i] != m_esel[i])
        nxt_pe[i] = 1'b0;
      else if (m_esel[i] && ((m_s[i] && !m_sd[i]) || (wr && address == 3'd5 && writedata[i])))
        nxt_pe[i] = 1'b1;
      else if (m_esel[i] && wr && address == 3'd1 && writedata[i])
        nxt_pe[i] = 1'b0;
      else
        nxt_pe[i] = m_pe[i];
    end
    m_sd = m_s;
`ifdef IRQ_SYNC_EN
    m_s    = m_sync;
    m_sync = irq_in;
`else
    m_s = irq_in;
`endif
    m_pe = nxt_pe;
    if (wr && address == 3'd2) m_mask = writedata[N-1:0];
    if (wr && address == 3'd3) m_esel = writedata[N-1:0];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_readdata", readdata, e.rd);
      check("sb_irq_out", 16'(irq_out), 16'(e.irq));
    end
  end

  initial begin
    exp_t z;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    check("rst_irq_out", 16'(irq_out), 16'h0000);
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a));
      check("rst_read", readdata, 16'h0000);
    end

    // Level source on bit 0
    wr_reg(ADDR_MASK, 16'h0001);
    irq_in = 8'h01;
    idle(3);
    check("lvl_irq_high", 16'(irq_out), 16'h0001);
    rd_reg(ADDR_VECTOR);
    check("lvl_vector", readdata, 16'h8000);
    wr_reg(ADDR_PENDING, 16'h0001);
    idle(1);
    check("lvl_w1c_noeffect", 16'(irq_out), 16'h0001);
    irq_in = 8'h00;
    idle(3);
    check("lvl_irq_low", 16'(irq_out), 16'h0000);

    // Edge source on bit 2
    wr_reg(ADDR_EDGE_SEL, 16'h0004);
    wr_reg(ADDR_MASK, 16'h0004);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    idle(3);
    rd_reg(ADDR_PENDING);
    check("edge_pending", readdata, 16'h0004);
    check("edge_irq_high", 16'(irq_out), 16'h0001);
    wr_reg(ADDR_PENDING, 16'h0004);
    idle(1);
    check("edge_cleared", 16'(irq_out), 16'h0000);

    // Rising edge lands on the same clock as the clear
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
`ifdef IRQ_SYNC_EN
    tick();
`endif
    wr_reg(ADDR_PENDING, 16'h0004);
    idle(2);
    rd_reg(ADDR_PENDING);
    check("set_beats_clear", readdata, 16'h0004);

    // Priority and mask
    wr_reg(ADDR_PENDING, 16'h00FF);
    wr_reg(ADDR_EDGE_SEL, 16'h00FF);
    wr_reg(ADDR_SWSET, 16'h0028);
    wr_reg(ADDR_MASK, 16'h0020);
    rd_reg(ADDR_VECTOR);
    check("prio_bit5", readdata, 16'h8005);
    wr_reg(ADDR_MASK, 16'h0028);
    rd_reg(ADDR_VECTOR);
    check("prio_bit3", readdata, 16'h8003);
    wr_reg(ADDR_MASK, 16'h0000);
    rd_reg(ADDR_VECTOR);
    check("prio_none", readdata, 16'h0000);
    idle(1);
    check("prio_irq_low", 16'(irq_out), 16'h0000);

    // Mode switch on bit 1
    wr_reg(ADDR_PENDING, 16'h00FF);
    irq_in = 8'h02;
    idle(3);
    wr_reg(ADDR_PENDING, 16'h00FF);
    wr_reg(ADDR_SWSET, 16'h0002);
    wr_reg(ADDR_EDGE_SEL, 16'h00FD);
    idle(1);
    rd_reg(ADDR_PENDING);
    check("mode_level_high", readdata, 16'h0002);
    irq_in = 8'h00;
    idle(3);
    rd_reg(ADDR_PENDING);
    check("mode_level_low", readdata, 16'h0000);
    irq_in = 8'h02;
    idle(3);
    rd_reg(ADDR_PENDING);
    check("mode_level_again", readdata, 16'h0002);
    wr_reg(ADDR_EDGE_SEL, 16'h00FF);
    rd_reg(ADDR_PENDING);
    check("mode_edge_cleared", readdata, 16'h0000);

    // Asynchronous reset while the interrupt is asserted
    wr_reg(ADDR_EDGE_SEL, 16'h0000);
    wr_reg(ADDR_MASK, 16'h0002);
    idle(2);
    check("pre_reset_irq", 16'(irq_out), 16'h0001);
    reset_n = 1'b0;
    exp_q.delete();
    z.rd = '0; z.irq = 1'b0;
    exp_q.push_back(z);
    model_reset();
    #1;
    check("async_rst_irq", 16'(irq_out), 16'h0000);
    check("async_rst_rd", readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    rd_reg(ADDR_MASK);
    check("post_rst_mask", readdata, 16'h0000);
    idle(3);
    check("post_rst_irq", 16'(irq_out), 16'h0000);

    // Randomized traffic against the reference model
    repeat (400) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) irq_in = N'($urandom);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
